// File: rtl/fb_swap_pkg.sv
// Shared types and CSR map for the frame-buffer swap scheduler.
package fb_swap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SWAP = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [2:0] CSR_CTRL     = 3'd0;
    localparam logic [2:0] CSR_STATUS   = 3'd1;
    localparam logic [2:0] CSR_BUF0     = 3'd2;
    localparam logic [2:0] CSR_BUF1     = 3'd3;
    localparam logic [2:0] CSR_SWAP     = 3'd4;
    localparam logic [2:0] CSR_VS_CNT   = 3'd5;
    localparam logic [2:0] CSR_SWAP_CNT = 3'd6;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_AUTO   = 2;

    localparam int STAT_PENDING = 0;
    localparam int STAT_FRONT   = 1;
    localparam int STAT_IRQ     = 2;

endpackage

// File: rtl/vs_edge_sync.sv
// Brings the raw VSYNC pin into clk and emits a one-cycle pulse on its sync-start edge.
module vs_edge_sync #(
    parameter bit VS_ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vga_vs,
    output logic vs_start
);

    // Flops reset to the inactive level so leaving reset never looks like a sync edge.
    localparam logic IDLE_LVL = VS_ACT_LOW ? 1'b1 : 1'b0;

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta     <= IDLE_LVL;
            sync     <= IDLE_LVL;
            sync_d   <= IDLE_LVL;
            vs_start <= 1'b0;
        end else begin
            meta     <= vga_vs;
            sync     <= meta;
            sync_d   <= sync;
            vs_start <= (sync != sync_d) && (sync != IDLE_LVL);
        end
    end

endmodule

// File: rtl/fb_swap_scheduler.sv
// Double-buffer scheduler: owns front/back frame pointers and swaps them only at vertical-sync start.
//
// state | meaning
// IDLE  | no swap outstanding
// WAIT  | swap requested, waiting for the next vs_start
// SWAP  | flip front index, bump swap counter
// ACK   | pulse render_ack, raise irq_flag
module fb_swap_scheduler
    import fb_swap_pkg::*;
#(
    parameter logic [31:0] BUF0_RST   = 32'h0000_0000,
    parameter logic [31:0] BUF1_RST   = 32'h0009_6000,
    parameter bit          VS_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    input  logic        vga_vs,
    input  logic        render_done,
    output logic        render_ack,
    output logic [31:0] frame_buffer_ptr,
    output logic [31:0] back_buffer_ptr,
    output logic        irq
);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  ctrl;
    logic [31:0] buf0;
    logic [31:0] buf1;
    logic [31:0] act0;
    logic [31:0] act1;
    logic        front;
    logic        front_nxt;
    logic        irq_flag;
    logic [31:0] vs_cnt;
    logic [31:0] swap_cnt;
    logic        vs_start;
    logic        pending;
    logic        wr_swap;
    logic        req;
    logic [31:0] rd_data;

    vs_edge_sync #(.VS_ACT_LOW(VS_ACT_LOW)) u_vs_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .vga_vs   (vga_vs),
        .vs_start (vs_start)
    );

    assign wr_swap   = avs_write && (avs_address == CSR_SWAP);
    assign req       = ctrl[CTRL_ENABLE] && (wr_swap || (render_done && ctrl[CTRL_AUTO]));
    assign pending   = (state == WAIT) || (state == SWAP);
    assign front_nxt = front ^ (state == SWAP);
    assign irq       = irq_flag & ctrl[CTRL_IRQ_EN];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        render_ack = 1'b0;
        case (state)
            IDLE: if (req) state_nxt = WAIT;
            WAIT: begin
                if (!ctrl[CTRL_ENABLE]) begin
                    state_nxt = IDLE;
                end else if (vs_start) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: state_nxt = ACK;
            ACK: begin
                render_ack = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (avs_address)
            CSR_CTRL:     rd_data = {29'd0, ctrl};
            CSR_STATUS:   rd_data = {29'd0, irq_flag, front, pending};
            CSR_BUF0:     rd_data = buf0;
            CSR_BUF1:     rd_data = buf1;
            CSR_VS_CNT:   rd_data = vs_cnt;
            CSR_SWAP_CNT: rd_data = swap_cnt;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl         <= '0;
            buf0         <= BUF0_RST;
            buf1         <= BUF1_RST;
            irq_flag     <= 1'b0;
            avs_readdata <= '0;
        end else begin
            avs_readdata <= avs_read ? rd_data : 32'd0;
            if (avs_write) begin
                case (avs_address)
                    CSR_CTRL: ctrl <= avs_writedata[2:0];
                    CSR_BUF0: buf0 <= avs_writedata;
                    CSR_BUF1: buf1 <= avs_writedata;
                    default: ;
                endcase
            end
            // Setting in ACK takes priority over a same-cycle write-1-to-clear.
            if (state == ACK) begin
                irq_flag <= 1'b1;
            end else if (avs_write && (avs_address == CSR_STATUS) && avs_writedata[STAT_IRQ]) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // BUF0/BUF1 are staged into act0/act1 only at sync start so scan-out never tears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act0             <= BUF0_RST;
            act1             <= BUF1_RST;
            front            <= 1'b0;
            vs_cnt           <= '0;
            swap_cnt         <= '0;
            frame_buffer_ptr <= BUF0_RST;
            back_buffer_ptr  <= BUF1_RST;
        end else begin
            if (vs_start) begin
                act0   <= buf0;
                act1   <= buf1;
                vs_cnt <= vs_cnt + 32'd1;
            end
            if (state == SWAP) begin
                swap_cnt <= swap_cnt + 32'd1;
            end
            front            <= front_nxt;
            frame_buffer_ptr <= front_nxt ? act1 : act0;
            back_buffer_ptr  <= front_nxt ? act0 : act1;
        end
    end

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Directed bench for fb_swap_scheduler: CSR access, vsync-aligned swaps, coalescing, cancel, irq, reset.
module tb_fb_swap_scheduler;

    logic        clk;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        vga_vs;
    logic        render_done;
    logic        render_ack;
    logic [31:0] frame_buffer_ptr;
    logic [31:0] back_buffer_ptr;
    logic        irq;

    int errors  = 0;
    int checks  = 0;
    int ack_cnt = 0;

    localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_BUF0 = 3'd2, A_BUF1 = 3'd3;
    localparam logic [2:0] A_SWAP = 3'd4, A_VSC = 3'd5, A_SWC = 3'd6, A_RSV = 3'd7;

    fb_swap_scheduler dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .vga_vs           (vga_vs),
        .render_done      (render_done),
        .render_ack       (render_ack),
        .frame_buffer_ptr (frame_buffer_ptr),
        .back_buffer_ptr  (back_buffer_ptr),
        .irq              (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (render_ack === 1'b1) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk);
        #1 d = avs_readdata;
        @(negedge clk);
        avs_read = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        render_done = 1'b1;
        @(negedge clk);
        render_done = 1'b0;
    endtask

    // Falling VSYNC edge; reports ack latency in negedges (0 = no ack) and pointers seen at ack.
    task automatic vsync(output int lat, output logic [31:0] fp, output logic [31:0] bp);
        lat = 0;
        fp  = '0;
        bp  = '0;
        @(negedge clk);
        vga_vs = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (render_ack === 1'b1 && lat == 0) begin
                lat = i;
                fp  = frame_buffer_ptr;
                bp  = back_buffer_ptr;
            end
        end
        vga_vs = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int          lat;
        int          ack0;
        logic [31:0] fp;
        logic [31:0] bp;
        logic [31:0] d;

        reset_n       = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        vga_vs        = 1'b1;
        render_done   = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // 1: reset state
        chk("t1_fbp", frame_buffer_ptr, 32'h0);
        chk("t1_bbp", back_buffer_ptr, 32'h0009_6000);
        chk("t1_irq", {31'd0, irq}, 32'd0);
        rd_chk("t1_ctrl", A_CTRL, 32'h0);
        rd_chk("t1_status", A_STAT, 32'h0);
        rd_chk("t1_buf0", A_BUF0, 32'h0);
        rd_chk("t1_buf1", A_BUF1, 32'h0009_6000);
        rd_chk("t1_swap_rd", A_SWAP, 32'h0);
        rd_chk("t1_vscnt", A_VSC, 32'h0);
        rd_chk("t1_swcnt", A_SWC, 32'h0);
        rd_chk("t1_rsv", A_RSV, 32'h0);

        // 2: CSR swap request, serviced at next vsync
        csr_wr(A_CTRL, 32'h1);
        csr_wr(A_SWAP, 32'h1);
        rd_chk("t2_pending", A_STAT, 32'h1);
        ack0 = ack_cnt;
        vsync(lat, fp, bp);
        chk("t2_ack_lat", lat, 32'd5);
        chk("t2_fbp_at_ack", fp, 32'h0009_6000);
        chk("t2_bbp_at_ack", bp, 32'h0);
        chk("t2_ack_count", ack_cnt - ack0, 32'd1);
        rd_chk("t2_status", A_STAT, 32'h6);
        rd_chk("t2_swcnt", A_SWC, 32'h1);
        rd_chk("t2_vscnt", A_VSC, 32'h1);

        // 3: auto mode, three render_done pulses coalesce into one swap
        csr_wr(A_CTRL, 32'h5);
        pulse_done();
        pulse_done();
        pulse_done();
        rd_chk("t3_pending", A_STAT, 32'h7);
        ack0 = ack_cnt;
        vsync(lat, fp, bp);
        chk("t3_ack_lat", lat, 32'd5);
        chk("t3_fbp_at_ack", fp, 32'h0);
        repeat (10) @(negedge clk);
        chk("t3_ack_count", ack_cnt - ack0, 32'd1);
        rd_chk("t3_swcnt", A_SWC, 32'h2);
        rd_chk("t3_status", A_STAT, 32'h4);

        // 4: render_done ignored without auto; cancel by clearing enable
        csr_wr(A_CTRL, 32'h1);
        pulse_done();
        rd_chk("t4_no_auto", A_STAT, 32'h4);
        csr_wr(A_SWAP, 32'h0);
        rd_chk("t4_pending", A_STAT, 32'h5);
        csr_wr(A_CTRL, 32'h0);
        rd_chk("t4_cancel", A_STAT, 32'h4);
        ack0 = ack_cnt;
        vsync(lat, fp, bp);
        chk("t4_no_ack", lat, 32'd0);
        chk("t4_ack_count", ack_cnt - ack0, 32'd0);
        chk("t4_fbp", frame_buffer_ptr, 32'h0);
        chk("t4_bbp", back_buffer_ptr, 32'h0009_6000);
        rd_chk("t4_swcnt", A_SWC, 32'h2);
        rd_chk("t4_vscnt", A_VSC, 32'h3);

        // 5: BUF0 rewrite only reaches the pointer at the next vsync
        csr_wr(A_CTRL, 32'h1);
        csr_wr(A_BUF0, 32'h0020_0000);
        rd_chk("t5_buf0", A_BUF0, 32'h0020_0000);
        repeat (5) @(negedge clk);
        chk("t5_fbp_hold", frame_buffer_ptr, 32'h0);
        vsync(lat, fp, bp);
        chk("t5_fbp_new", frame_buffer_ptr, 32'h0020_0000);
        chk("t5_bbp", back_buffer_ptr, 32'h0009_6000);
        rd_chk("t5_vscnt", A_VSC, 32'h4);

        // 6: irq gating, W1C, then reset while a swap is pending
        csr_wr(A_SWAP, 32'h1);
        vsync(lat, fp, bp);
        chk("t6_ack_lat", lat, 32'd5);
        chk("t6_fbp_at_ack", fp, 32'h0009_6000);
        chk("t6_bbp_at_ack", bp, 32'h0020_0000);
        chk("t6_irq_masked", {31'd0, irq}, 32'd0);
        csr_wr(A_CTRL, 32'h3);
        chk("t6_irq_on", {31'd0, irq}, 32'd1);
        csr_wr(A_STAT, 32'h4);
        chk("t6_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("t6_status", A_STAT, 32'h2);
        csr_wr(A_SWAP, 32'h1);
        rd_chk("t6_pending", A_STAT, 32'h3);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_fbp", frame_buffer_ptr, 32'h0);
        chk("t6_rst_bbp", back_buffer_ptr, 32'h0009_6000);
        chk("t6_rst_ack", {31'd0, render_ack}, 32'd0);
        chk("t6_rst_rdata", avs_readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd_chk("t6_rst_ctrl", A_CTRL, 32'h0);
        rd_chk("t6_rst_status", A_STAT, 32'h0);
        rd_chk("t6_rst_buf0", A_BUF0, 32'h0);
        rd_chk("t6_rst_swcnt", A_SWC, 32'h0);
        ack0 = ack_cnt;
        vsync(lat, fp, bp);
        chk("t6_discarded", ack_cnt - ack0, 32'd0);
        rd_chk("t6_vscnt", A_VSC, 32'h1);

        // read and write in the same cycle returns the pre-write value
        @(negedge clk);
        avs_address   = A_BUF1;
        avs_writedata = 32'h0000_0123;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(posedge clk);
        #1 d = avs_readdata;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        chk("rw_old", d, 32'h0009_6000);
        rd_chk("rw_new", A_BUF1, 32'h0000_0123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
